// File: rtl/apb_opb_bridge_if.sv
// Bus bundle between an APB3 master, the bridge, and the downstream OPB address decoder.
// Signal names match the legacy flat port list so existing hookups map one-to-one.
interface apb_opb_bridge_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        OPB_RE;
  logic        OPB_WE;
  logic [31:0] OPB_ADDR;
  logic [31:0] OPB_DI;
  logic [31:0] OPB_DO;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, OPB_DO,
    output PRDATA, PREADY, PSLVERR, OPB_RE, OPB_WE, OPB_ADDR, OPB_DI
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, OPB_DO,
    input  PRDATA, PREADY, PSLVERR, OPB_RE, OPB_WE, OPB_ADDR, OPB_DI
  );
endinterface

// File: rtl/apb_opb_bridge.sv
// APB3 slave to OPB master bridge: one single-cycle OPB strobe per APB access,
// fixed-latency read capture, PSLVERR for out-of-window or misaligned addresses.
module apb_opb_bridge #(
  parameter logic [31:0] APB_BASE     = 32'h0000_0000,
  parameter logic [31:0] APB_SIZE     = 32'h0001_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic             OPB_CLK,
  input  logic             OPB_RSTN,
  apb_opb_bridge_if.slave  bus,
  output logic             BUSY,
  output logic [15:0]      ERR_CNT
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] STROBE  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]  state;
  logic [2:0]  wait_cnt;
  logic        is_read;
  logic        aborted;
  logic        opb_re;
  logic        opb_we;
  logic [31:0] opb_addr;
  logic [31:0] opb_di;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [15:0] err_cnt;

  logic        access;
  logic [31:0] offset;
  logic        in_window;
  logic        addr_ok;

  assign access    = bus.PSEL && bus.PENABLE;
  assign offset    = bus.PADDR - APB_BASE;
  // Lower-bound compare first so a wrapped subtraction can never look in-window.
  assign in_window = (bus.PADDR >= APB_BASE) && (offset < APB_SIZE);
  assign addr_ok   = in_window && (bus.PADDR[1:0] == 2'b00);

  always_ff @(posedge OPB_CLK or negedge OPB_RSTN) begin
    if (!OPB_RSTN) begin
      state    <= IDLE;
      wait_cnt <= '0;
      is_read  <= 1'b0;
      aborted  <= 1'b0;
      opb_re   <= 1'b0;
      opb_we   <= 1'b0;
      opb_addr <= '0;
      opb_di   <= '0;
      prdata   <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      opb_re <= 1'b0;
      opb_we <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (addr_ok) begin
              opb_addr <= offset;
              opb_di   <= bus.PWDATA;
              opb_we   <= bus.PWRITE;
              opb_re   <= !bus.PWRITE;
              is_read  <= !bus.PWRITE;
              aborted  <= 1'b0;
              state    <= STROBE;
            end else begin
              pready  <= 1'b1;
              pslverr <= 1'b1;
              prdata  <= '0;
              if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
              state   <= DONE;
            end
          end
        end
        STROBE: begin
          if (is_read) begin
            // A read whose PSEL already dropped still waits out the decoder latency.
            wait_cnt <= 3'(READ_LATENCY - 1);
            aborted  <= !bus.PSEL;
            state    <= RD_WAIT;
          end else if (bus.PSEL) begin
            pready <= 1'b1;
            state  <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (wait_cnt == 3'd0) begin
            if (aborted || !bus.PSEL) begin
              state <= IDLE;
            end else begin
              prdata <= bus.OPB_DO;
              pready <= 1'b1;
              state  <= DONE;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
            if (!bus.PSEL) aborted <= 1'b1;
          end
        end
        default: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.OPB_RE   = opb_re;
  assign bus.OPB_WE   = opb_we;
  assign bus.OPB_ADDR = opb_addr;
  assign bus.OPB_DI   = opb_di;
  assign bus.PRDATA   = prdata;
  assign bus.PREADY   = pready;
  assign bus.PSLVERR  = pslverr;
  assign BUSY         = (state != IDLE);
  assign ERR_CNT      = err_cnt;

endmodule
